// File: rtl/ex_mem_stage.sv
// ex_mem_stage
// EX/MEM pipeline register with stall/bubble/flush control and two
// saturating performance counters.
//
// Ports:
//   clk, rst            : single clock, synchronous active-high reset
//   in_valid .. in_memaddr : EX-side result fields
//   stall               : pipeline stall vector; only bits STAGE and STAGE+1 matter
//   flush               : clear the stage contents
//   cnt_clr             : zero both counters (data fields unaffected)
//   out_valid .. out_memaddr : registered MEM-side fields
//   stall_cnt           : cycles with this stage stalled (saturating)
//   bubble_cnt          : bubble cycles inserted by this stage (saturating)
module ex_mem_stage #(
  parameter int DATA_W    = 32,
  parameter int REGADDR_W = 5,
  parameter int MEMOP_W   = 4,
  parameter int STALL_W   = 6,
  parameter int STAGE     = 3,
  parameter bit DROP_R0   = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [REGADDR_W-1:0] in_wd,
  input  logic                 in_wreg,
  input  logic [DATA_W-1:0]    in_wdata,
  input  logic [MEMOP_W-1:0]   in_memop,
  input  logic [DATA_W-1:0]    in_memaddr,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic                 cnt_clr,
  output logic                 out_valid,
  output logic [REGADDR_W-1:0] out_wd,
  output logic                 out_wreg,
  output logic [DATA_W-1:0]    out_wdata,
  output logic [MEMOP_W-1:0]   out_memop,
  output logic [DATA_W-1:0]    out_memaddr,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
);

  logic                 r_valid;
  logic [REGADDR_W-1:0] r_wd;
  logic                 r_wreg;
  logic [DATA_W-1:0]    r_wdata;
  logic [MEMOP_W-1:0]   r_memop;
  logic [DATA_W-1:0]    r_memaddr;
  logic [CNT_W-1:0]     r_stall_cnt;
  logic [CNT_W-1:0]     r_bubble_cnt;

  logic w_stall_here;
  logic w_stall_next;
  logic w_bubble;
  logic w_wreg_in;

  assign w_stall_here = stall[STAGE];
  assign w_stall_next = stall[STAGE+1];
  // This stage is held while the next one advances: emit an empty slot.
  assign w_bubble     = w_stall_here & ~w_stall_next;
  // Register 0 is hardwired, so a write to it is dropped at this point.
  assign w_wreg_in    = in_wreg & ~(DROP_R0 && (in_wd == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_wd         <= '0;
      r_wreg       <= 1'b0;
      r_wdata      <= '0;
      r_memop      <= '0;
      r_memaddr    <= '0;
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      // Data fields: flush > bubble > load > hold.
      if (flush || w_bubble || (!w_stall_here && !in_valid)) begin
        r_valid   <= 1'b0;
        r_wd      <= '0;
        r_wreg    <= 1'b0;
        r_wdata   <= '0;
        r_memop   <= '0;
        r_memaddr <= '0;
      end else if (!w_stall_here) begin
        r_valid   <= 1'b1;
        r_wd      <= in_wd;
        r_wreg    <= w_wreg_in;
        r_wdata   <= in_wdata;
        r_memop   <= in_memop;
        r_memaddr <= in_memaddr;
      end

      // Counters: clear wins over increment; flush still counts as a stall
      // cycle but never as a bubble.
      if (cnt_clr) begin
        r_stall_cnt  <= '0;
        r_bubble_cnt <= '0;
      end else begin
        if (w_stall_here && !(&r_stall_cnt))
          r_stall_cnt <= r_stall_cnt + 1'b1;
        if (w_bubble && !flush && !(&r_bubble_cnt))
          r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
    end
  end

  assign out_valid   = r_valid;
  assign out_wd      = r_wd;
  assign out_wreg    = r_wreg;
  assign out_wdata   = r_wdata;
  assign out_memop   = r_memop;
  assign out_memaddr = r_memaddr;
  assign stall_cnt   = r_stall_cnt;
  assign bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: directed vectors with literal expectations,
// plus a behavioural model compared against two DUT instances (default
// counter width and a 2-bit counter width) on every negative clock edge.
module tb_ex_mem_stage;

  localparam int DATA_W    = 32;
  localparam int REGADDR_W = 5;
  localparam int MEMOP_W   = 4;
  localparam int STALL_W   = 6;
  localparam int STAGE     = 3;
  localparam int MAX_A     = 65535;
  localparam int MAX_B     = 3;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic [REGADDR_W-1:0] in_wd;
  logic                 in_wreg;
  logic [DATA_W-1:0]    in_wdata;
  logic [MEMOP_W-1:0]   in_memop;
  logic [DATA_W-1:0]    in_memaddr;
  logic [STALL_W-1:0]   stall;
  logic                 flush;
  logic                 cnt_clr;

  logic                 a_valid, b_valid;
  logic [REGADDR_W-1:0] a_wd, b_wd;
  logic                 a_wreg, b_wreg;
  logic [DATA_W-1:0]    a_wdata, b_wdata;
  logic [MEMOP_W-1:0]   a_memop, b_memop;
  logic [DATA_W-1:0]    a_memaddr, b_memaddr;
  logic [15:0]          a_scnt, a_bcnt;
  logic [1:0]           b_scnt, b_bcnt;

  int n_checks = 0;
  int n_errors = 0;

  ex_mem_stage dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_wd(in_wd), .in_wreg(in_wreg),
    .in_wdata(in_wdata), .in_memop(in_memop), .in_memaddr(in_memaddr),
    .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .out_valid(a_valid), .out_wd(a_wd), .out_wreg(a_wreg), .out_wdata(a_wdata),
    .out_memop(a_memop), .out_memaddr(a_memaddr),
    .stall_cnt(a_scnt), .bubble_cnt(a_bcnt)
  );

  ex_mem_stage #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_wd(in_wd), .in_wreg(in_wreg),
    .in_wdata(in_wdata), .in_memop(in_memop), .in_memaddr(in_memaddr),
    .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .out_valid(b_valid), .out_wd(b_wd), .out_wreg(b_wreg), .out_wdata(b_wdata),
    .out_memop(b_memop), .out_memaddr(b_memaddr),
    .stall_cnt(b_scnt), .bubble_cnt(b_bcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          valid;
    int unsigned wd;
    bit          wreg;
    int unsigned wdata;
    int unsigned memop;
    int unsigned memaddr;
  } slot_t;

  slot_t       m_slot;
  int unsigned m_scnt_a, m_bcnt_a, m_scnt_b, m_bcnt_b;
  bit          m_started = 1'b0;
  slot_t       empty_slot = '{0, 0, 0, 0, 0, 0};

  always @(posedge clk) begin
    string action;
    bit here, next;
    here = stall[STAGE];
    next = stall[STAGE+1];
    if (rst)                action = "reset";
    else if (flush)         action = "flush";
    else if (here && !next) action = "bubble";
    else if (!here)         action = "load";
    else                    action = "hold";

    case (action)
      "reset": begin
        m_slot = empty_slot;
        m_scnt_a = 0; m_bcnt_a = 0; m_scnt_b = 0; m_bcnt_b = 0;
        m_started = 1'b1;
      end
      "flush", "bubble": m_slot = empty_slot;
      "load": begin
        if (!in_valid) m_slot = empty_slot;
        else begin
          m_slot.valid   = 1;
          m_slot.wd      = in_wd;
          m_slot.wreg    = in_wreg && (in_wd != 0);
          m_slot.wdata   = in_wdata;
          m_slot.memop   = in_memop;
          m_slot.memaddr = in_memaddr;
        end
      end
      default: ;
    endcase

    if (action != "reset") begin
      if (cnt_clr) begin
        m_scnt_a = 0; m_bcnt_a = 0; m_scnt_b = 0; m_bcnt_b = 0;
      end else begin
        if (here) begin
          if (m_scnt_a < MAX_A) m_scnt_a++;
          if (m_scnt_b < MAX_B) m_scnt_b++;
        end
        if (action == "bubble") begin
          if (m_bcnt_a < MAX_A) m_bcnt_a++;
          if (m_bcnt_b < MAX_B) m_bcnt_b++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_started) begin
      chk("a_valid",   a_valid,   m_slot.valid);
      chk("a_wd",      a_wd,      m_slot.wd);
      chk("a_wreg",    a_wreg,    m_slot.wreg);
      chk("a_wdata",   a_wdata,   m_slot.wdata);
      chk("a_memop",   a_memop,   m_slot.memop);
      chk("a_memaddr", a_memaddr, m_slot.memaddr);
      chk("a_stall_cnt",  a_scnt, m_scnt_a);
      chk("a_bubble_cnt", a_bcnt, m_bcnt_a);
      chk("b_valid",   b_valid,   m_slot.valid);
      chk("b_wdata",   b_wdata,   m_slot.wdata);
      chk("b_wreg",    b_wreg,    m_slot.wreg);
      chk("b_stall_cnt",  b_scnt, m_scnt_b);
      chk("b_bubble_cnt", b_bcnt, m_bcnt_b);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit v, input int wd, input bit wr, input logic [31:0] wdata,
                       input int memop, input logic [31:0] maddr);
    in_valid = v; in_wd = wd[REGADDR_W-1:0]; in_wreg = wr; in_wdata = wdata;
    in_memop = memop[MEMOP_W-1:0]; in_memaddr = maddr;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; cnt_clr = 1'b0; stall = '0;
    drive(0, 0, 0, 0, 0, 0);

    // Reset for 2 cycles
    tick(2);
    chk("rst_valid", a_valid, 0);
    chk("rst_wdata", a_wdata, 0);
    chk("rst_scnt",  a_scnt, 0);
    chk("rst_bcnt",  a_bcnt, 0);
    $display("txn reset: valid=%0d scnt=%0d bcnt=%0d", a_valid, a_scnt, a_bcnt);

    // Load
    rst = 1'b0;
    drive(1, 5, 1, 32'hDEADBEEF, 2, 32'h100);
    tick(1);
    chk("load_wd", a_wd, 5);
    chk("load_wreg", a_wreg, 1);
    chk("load_wdata", a_wdata, 32'hDEADBEEF);
    chk("load_valid", a_valid, 1);
    chk("load_memaddr", a_memaddr, 32'h100);
    $display("txn load: wd=%0d wdata=%h valid=%0d", a_wd, a_wdata, a_valid);

    // Hold for 3 cycles while inputs change
    drive(1, 9, 1, 32'h11111111, 3, 32'h200);
    stall = 6'b011000;
    tick(3);
    chk("hold_wdata", a_wdata, 32'hDEADBEEF);
    chk("hold_wd", a_wd, 5);
    chk("hold_scnt", a_scnt, 3);
    chk("hold_bcnt", a_bcnt, 0);
    $display("txn hold x3: wdata=%h scnt=%0d", a_wdata, a_scnt);

    // Bubble
    stall = 6'b001000;
    tick(1);
    chk("bub_valid", a_valid, 0);
    chk("bub_wdata", a_wdata, 0);
    chk("bub_memop", a_memop, 0);
    chk("bub_bcnt", a_bcnt, 1);
    chk("bub_scnt", a_scnt, 4);
    chk("bub_b_scnt", b_scnt, 3);
    $display("txn bubble: valid=%0d bcnt=%0d scnt=%0d", a_valid, a_bcnt, a_scnt);

    // R0 drop
    stall = '0;
    drive(1, 0, 1, 7, 1, 32'h40);
    tick(1);
    chk("r0_wreg", a_wreg, 0);
    chk("r0_wdata", a_wdata, 7);
    chk("r0_valid", a_valid, 1);
    $display("txn r0: wreg=%0d wdata=%0d valid=%0d", a_wreg, a_wdata, a_valid);

    // Flush with bubble-type stall
    flush = 1'b1;
    stall = 6'b001000;
    tick(1);
    chk("fl_valid", a_valid, 0);
    chk("fl_wdata", a_wdata, 0);
    chk("fl_bcnt", a_bcnt, 1);
    chk("fl_scnt", a_scnt, 5);
    $display("txn flush: valid=%0d bcnt=%0d scnt=%0d", a_valid, a_bcnt, a_scnt);
    flush = 1'b0;

    // Load with in_valid=0 after a valid load
    stall = '0;
    drive(1, 3, 1, 32'hA5A5A5A5, 5, 32'h80);
    tick(1);
    drive(0, 3, 1, 32'h5A5A5A5A, 5, 32'h84);
    tick(1);
    chk("inv_valid", a_valid, 0);
    chk("inv_wdata", a_wdata, 0);
    chk("inv_wd", a_wd, 0);
    $display("txn invalid load: valid=%0d wdata=%h", a_valid, a_wdata);

    // Ignored stall bits: only bits 3/4 matter
    stall = 6'b100111;
    drive(1, 12, 1, 32'hCAFE0001, 6, 32'hC0);
    tick(1);
    chk("ign_wdata", a_wdata, 32'hCAFE0001);
    chk("ign_scnt", a_scnt, 5);
    $display("txn ignored bits: wdata=%h scnt=%0d", a_wdata, a_scnt);

    // Saturation on the 2-bit instance, then clear while held
    stall = '0;
    cnt_clr = 1'b1;
    tick(1);
    chk("clr_scnt", a_scnt, 0);
    cnt_clr = 1'b0;
    stall = 6'b011000;
    tick(5);
    chk("sat_b_scnt", b_scnt, 3);
    chk("sat_a_scnt", a_scnt, 5);
    cnt_clr = 1'b1;
    tick(1);
    chk("satclr_b_scnt", b_scnt, 0);
    chk("satclr_a_scnt", a_scnt, 0);
    chk("satclr_wdata", a_wdata, 32'hCAFE0001);
    $display("txn saturate/clear: b_scnt=%0d wdata=%h", b_scnt, a_wdata);
    cnt_clr = 1'b0;

    // Reset mid-hold
    stall = '0;
    drive(1, 4, 1, 32'h1234, 2, 32'h10);
    tick(1);
    stall = 6'b011000;
    tick(2);
    chk("pre_rst_wdata", a_wdata, 32'h1234);
    rst = 1'b1; flush = 1'b1; cnt_clr = 1'b1;
    tick(1);
    chk("mrst_wdata", a_wdata, 0);
    chk("mrst_valid", a_valid, 0);
    chk("mrst_scnt", a_scnt, 0);
    rst = 1'b0; flush = 1'b0; cnt_clr = 1'b0; stall = '0;
    drive(1, 6, 1, 32'h5678, 1, 32'h20);
    tick(1);
    chk("post_rst_wdata", a_wdata, 32'h5678);
    chk("post_rst_wd", a_wd, 6);
    $display("txn reset mid-hold: wdata=%h valid=%0d", a_wdata, a_valid);

    // Mixed vectors, checked by the model every cycle
    for (int i = 0; i < 80; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom, $urandom_range(0, 15), $urandom);
      stall   = STALL_W'($urandom);
      flush   = ($urandom_range(0, 9) == 0);
      cnt_clr = ($urandom_range(0, 19) == 0);
      rst     = ($urandom_range(0, 29) == 0);
      tick(1);
      $display("txn mix %0d: valid=%0d wdata=%h scnt=%0d bcnt=%0d",
               i, a_valid, a_wdata, a_scnt, a_bcnt);
    end
    rst = 1'b0; flush = 1'b0; cnt_clr = 1'b0; stall = '0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
